// File: rtl/jk_clock_divider.sv
// jk_clock_divider: programmable divide-by-D tick/square generator with boundary-aligned divisor reload
module jk_clock_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             tick,
  output logic             q_out,
  output logic [WIDTH-1:0] count
);
  if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** WIDTH) - 1) begin : g_bad_div
    $error("jk_clock_divider: DEFAULT_DIV out of range");
  end
  logic [WIDTH-1:0] div_reg, pend_val, count_nx;
  logic [WIDTH:0]   half;
  logic             pend_flag, wrap, apply, ld_ok, tick_nx, q_nx;
  always_comb begin
    wrap     = count == div_reg - WIDTH'(1);
    apply    = pend_flag && (!en || wrap);
    ld_ok    = div_load && (div_in >= WIDTH'(2));
    half     = ({1'b0, div_reg} + (WIDTH+1)'(1)) >> 1;
    count_nx = apply ? '0 : !en ? count : wrap ? '0 : count + WIDTH'(1);
    tick_nx  = en && wrap;
    // square mode: J when the period restarts, K at ceil(D/2), hold otherwise
    q_nx     = !en ? q_out : !mode ? tick_nx : count_nx == '0 ? 1'b1 :
               {1'b0, count_nx} == half ? 1'b0 : q_out;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      div_reg   <= WIDTH'(DEFAULT_DIV);
      pend_val  <= '0;
      pend_flag <= 1'b0;
      tick      <= 1'b0;
      q_out     <= 1'b0;
      div_ack   <= 1'b0;
      div_err   <= 1'b0;
    end else begin
      count     <= count_nx;
      tick      <= tick_nx;
      q_out     <= q_nx;
      div_ack   <= apply;
      div_err   <= div_load && !ld_ok;
      div_reg   <= apply ? pend_val : div_reg;
      pend_val  <= ld_ok ? div_in : pend_val;
      pend_flag <= ld_ok || (pend_flag && !apply);
    end
  end
endmodule

// File: tb/tb_jk_clock_divider.sv
// tb_jk_clock_divider: directed-vector bench for jk_clock_divider
module tb_jk_clock_divider;
  logic       clk = 1'b0, reset = 1'b1, en = 1'b0, mode = 1'b0, div_load = 1'b0;
  logic [7:0] div_in = '0;
  logic       div_ack, div_err, tick, q_out;
  logic [7:0] count;
  int         n_vec = 0, n_bad = 0;
  jk_clock_divider #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .div_in(div_in),
    .div_load(div_load), .div_ack(div_ack), .div_err(div_err),
    .tick(tick), .q_out(q_out), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!div_ack && n < 40);
    chk(tag, int'(div_ack), 1);
  endtask
  task automatic load(input int d);
    div_in   = 8'(d);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_count", int'(count), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_q", int'(q_out), 0);
    chk("rst_ack", int'(div_ack), 0);
    chk("rst_err", int'(div_err), 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_count", int'(count), 0);
      chk("frz_tick", int'(tick), 0);
    end
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("d4_count", int'(count), i % 4);
      chk("d4_tick", int'(tick), int'(i % 4 == 0));
      chk("d4_q", int'(q_out), int'(i % 4 == 0));
    end
    mode = 1'b1;
    load(5);
    wait_ack("ack_d5");
    chk("d5_ack_count", int'(count), 0);
    chk("d5_ack_tick", int'(tick), 1);
    chk("d5_ack_q", int'(q_out), 1);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("d5_count", int'(count), i % 5);
      chk("d5_q", int'(q_out), int'(i % 5 < 3));
      chk("d5_tick", int'(tick), int'(i % 5 == 0));
    end
    load(6);
    wait_ack("ack_d6");
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("d6_count", int'(count), i % 6);
      chk("d6_q", int'(q_out), int'(i % 6 < 3));
    end
    load(8);
    wait_ack("ack_d8");
    step();
    step();
    chk("d8_count2", int'(count), 2);
    load(3);
    chk("ld3_count", int'(count), 3);
    chk("ld3_ack", int'(div_ack), 0);
    for (int i = 4; i <= 7; i++) begin
      step();
      chk("ld3_wait_count", int'(count), i);
      chk("ld3_wait_ack", int'(div_ack), 0);
    end
    step();
    chk("ld3_ack_pulse", int'(div_ack), 1);
    chk("ld3_ack_count", int'(count), 0);
    chk("ld3_ack_tick", int'(tick), 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("d3_count", int'(count), i % 3);
      chk("d3_tick", int'(tick), int'(i % 3 == 0));
      chk("d3_ack", int'(div_ack), 0);
    end
    load(1);
    chk("err_pulse", int'(div_err), 1);
    chk("err_noack", int'(div_ack), 0);
    chk("err_count", int'(count), 1);
    step();
    chk("err_clear", int'(div_err), 0);
    chk("err_count2", int'(count), 2);
    step();
    chk("err_keep_d3", int'(count), 0);
    chk("err_keep_tick", int'(tick), 1);
    load(10);
    load(6);
    chk("two_ld_count", int'(count), 2);
    chk("two_ld_noack", int'(div_ack), 0);
    step();
    chk("two_ld_ack", int'(div_ack), 1);
    chk("two_ld_count0", int'(count), 0);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("two_ld_single_ack", int'(div_ack), 0);
      chk("two_ld_d6_count", int'(count), i % 6);
      chk("two_ld_d6_tick", int'(tick), int'(i % 6 == 0));
    end
    en = 1'b0;
    load(4);
    chk("off_ld_count", int'(count), 0);
    chk("off_ld_noack", int'(div_ack), 0);
    step();
    chk("off_apply_ack", int'(div_ack), 1);
    chk("off_apply_q", int'(q_out), 1);
    chk("off_apply_tick", int'(tick), 0);
    en = 1'b1;
    step();
    step();
    chk("pre_rst_count", int'(count), 2);
    load(7);
    chk("pre_rst_count3", int'(count), 3);
    #2 reset = 1'b1;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_tick", int'(tick), 0);
    chk("async_q", int'(q_out), 0);
    chk("async_ack", int'(div_ack), 0);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("post_rst_count", int'(count), i % 4);
      chk("post_rst_tick", int'(tick), int'(i % 4 == 0));
      chk("post_rst_noack", int'(div_ack), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
